// File: rtl/lock_controller.sv
// Keypad lock state controller: compares completed entries against the
// stored PIN and tracks locked / unlocked / PIN-change / lockout state.
module lock_controller #(
    parameter logic [15:0] DEFAULT_PIN    = 16'h4321,
    parameter int          MAX_TRIES      = 3,
    parameter int          LOCKOUT_CYCLES = 2500,
    parameter int          UNLOCK_CYCLES  = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pin_valid,
    input  logic [15:0] user_pin,
    input  logic        set_req,
    output logic [1:0]  status,
    output logic [15:0] stored_pin,
    output logic [1:0]  fail_count,
    output logic        unlock_pulse,
    output logic        bad_pin
);

    localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ?
                          LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] UNL_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [1:0]    MAX_FAIL  = 2'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_SET      = 2'b10,
        ST_LOCKOUT  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pin_q, pin_d;
    logic [1:0]  fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        unlock_q, unlock_d;
    logic        bad_q, bad_d;

    logic        timer_zero;
    logic [1:0]  fail_inc;
    logic        new_pin_ok;

    function automatic logic all_bcd(input logic [15:0] p);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (p[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    assign timer_zero = (timer_q == '0);
    assign fail_inc   = (fail_q >= MAX_FAIL) ? MAX_FAIL : fail_q + 2'd1;
    assign new_pin_ok = all_bcd(user_pin);

    // Strobes take priority over timeouts in every state that accepts them.
    always_comb begin
        state_d  = state_q;
        pin_d    = pin_q;
        fail_d   = fail_q;
        timer_d  = timer_zero ? '0 : timer_q - TW'(1);
        unlock_d = 1'b0;
        bad_d    = 1'b0;

        unique case (state_q)
            ST_LOCKED: begin
                if (pin_valid) begin
                    if (user_pin == pin_q) begin
                        state_d  = ST_UNLOCKED;
                        fail_d   = 2'd0;
                        unlock_d = 1'b1;
                        timer_d  = UNL_LOAD;
                    end else begin
                        bad_d  = 1'b1;
                        fail_d = fail_inc;
                        if (fail_inc == MAX_FAIL) begin
                            state_d = ST_LOCKOUT;
                            timer_d = LOCK_LOAD;
                        end
                    end
                end
            end
            ST_LOCKOUT: begin
                if (timer_zero) begin
                    state_d = ST_LOCKED;
                    fail_d  = 2'd0;
                end
            end
            ST_UNLOCKED: begin
                if (pin_valid) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (set_req) begin
                    state_d = ST_SET;
                    timer_d = UNL_LOAD;
                end else if (timer_zero) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_SET: begin
                if (pin_valid) begin
                    if (new_pin_ok) begin
                        pin_d   = user_pin;
                        state_d = ST_LOCKED;
                        timer_d = '0;
                    end else begin
                        bad_d   = 1'b1;
                        timer_d = UNL_LOAD;
                    end
                end else if (set_req) begin
                    state_d = ST_UNLOCKED;
                    timer_d = UNL_LOAD;
                end else if (timer_zero) begin
                    state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOCKED;
            pin_q    <= DEFAULT_PIN;
            fail_q   <= 2'd0;
            timer_q  <= '0;
            unlock_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pin_q    <= pin_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            unlock_q <= unlock_d;
            bad_q    <= bad_d;
        end
    end

    assign status       = state_q;
    assign stored_pin   = pin_q;
    assign fail_count   = fail_q;
    assign unlock_pulse = unlock_q;
    assign bad_pin      = bad_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: a cycle-level reference model
// predicts every output; a monitor compares after each clock edge.
module tb_lock_controller;

    localparam int          LOCK_C = 8;
    localparam int          UNL_C  = 16;
    localparam int          TRIES  = 3;
    localparam logic [15:0] DEF    = 16'h4321;

    localparam int M_LOCKED   = 0;
    localparam int M_UNLOCKED = 1;
    localparam int M_SET      = 2;
    localparam int M_LOCKOUT  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pin_valid = 1'b0;
    logic [15:0] user_pin = 16'h0;
    logic        set_req = 1'b0;
    logic [1:0]  status;
    logic [15:0] stored_pin;
    logic [1:0]  fail_count;
    logic        unlock_pulse;
    logic        bad_pin;

    lock_controller #(
        .DEFAULT_PIN   (DEF),
        .MAX_TRIES     (TRIES),
        .LOCKOUT_CYCLES(LOCK_C),
        .UNLOCK_CYCLES (UNL_C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pin_valid   (pin_valid),
        .user_pin    (user_pin),
        .set_req     (set_req),
        .status      (status),
        .stored_pin  (stored_pin),
        .fail_count  (fail_count),
        .unlock_pulse(unlock_pulse),
        .bad_pin     (bad_pin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] pin;
        logic [1:0]  fc;
        logic        up;
        logic        bp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          m_st;
    logic [15:0] m_pin;
    int          m_fails;
    int          m_left;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    function automatic logic digits_ok(input logic [15:0] p);
        for (int i = 0; i < 4; i++) begin
            if (((p >> (4 * i)) & 16'hF) > 16'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_st    = M_LOCKED;
        m_pin   = DEF;
        m_fails = 0;
        m_left  = 0;
    endfunction

    // m_left counts the cycles still to be spent in a timed state.
    function automatic exp_t model_next(input logic pv,
                                        input logic [15:0] pin,
                                        input logic sr);
        exp_t e;
        logic up = 1'b0;
        logic bp = 1'b0;
        case (m_st)
            M_LOCKED: begin
                if (pv) begin
                    if (pin == m_pin) begin
                        m_st = M_UNLOCKED; m_fails = 0;
                        up = 1'b1; m_left = UNL_C;
                    end else begin
                        bp = 1'b1;
                        if (m_fails < TRIES) m_fails++;
                        if (m_fails == TRIES) begin
                            m_st = M_LOCKOUT; m_left = LOCK_C;
                        end
                    end
                end
            end
            M_LOCKOUT: begin
                m_left--;
                if (m_left == 0) begin
                    m_st = M_LOCKED; m_fails = 0;
                end
            end
            M_UNLOCKED: begin
                if (pv) m_st = M_LOCKED;
                else if (sr) begin
                    m_st = M_SET; m_left = UNL_C;
                end else begin
                    m_left--;
                    if (m_left == 0) m_st = M_LOCKED;
                end
            end
            default: begin
                if (pv) begin
                    if (digits_ok(pin)) begin
                        m_pin = pin; m_st = M_LOCKED;
                    end else begin
                        bp = 1'b1; m_left = UNL_C;
                    end
                end else if (sr) begin
                    m_st = M_UNLOCKED; m_left = UNL_C;
                end else begin
                    m_left--;
                    if (m_left == 0) m_st = M_LOCKED;
                end
            end
        endcase
        e.st  = 2'(m_st);
        e.pin = m_pin;
        e.fc  = 2'(m_fails);
        e.up  = up;
        e.bp  = bp;
        return e;
    endfunction

    task automatic step(input logic pv, input logic [15:0] pin,
                        input logic sr);
        @(negedge clk);
        pin_valid = pv;
        user_pin  = pin;
        set_req   = sr;
        sb_q.push_back(model_next(pv, pin, sr));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pin_valid = 1'b0;
        set_req   = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_pin", 32'(stored_pin), 32'(DEF));
        chk("rst_fail", 32'(fail_count), 32'd0);
        chk("rst_unlock", 32'(unlock_pulse), 32'd0);
        chk("rst_bad", 32'(bad_pin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("status", 32'(status), 32'(e.st));
            chk("stored_pin", 32'(stored_pin), 32'(e.pin));
            chk("fail_count", 32'(fail_count), 32'(e.fc));
            chk("unlock_pulse", 32'(unlock_pulse), 32'(e.up));
            chk("bad_pin", 32'(bad_pin), 32'(e.bp));
        end
    end

    initial begin
        logic [15:0] rp;
        model_reset();
        do_reset();

        step(1'b1, 16'h4321, 1'b0);
        idle(2);
        step(1'b1, 16'h0000, 1'b0);

        repeat (3) step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h4321, 1'b0);
        step(1'b1, 16'h4321, 1'b1);
        idle(9);

        step(1'b1, 16'h4321, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h8765, 1'b0);
        step(1'b1, 16'h4321, 1'b0);
        step(1'b1, 16'h8765, 1'b0);

        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h4A21, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        idle(18);

        step(1'b1, 16'h8765, 1'b0);
        step(1'b1, 16'h0, 1'b1);
        step(1'b1, 16'h8765, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        idle(18);

        step(1'b1, 16'h8765, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h1357, 1'b0);
        step(1'b1, 16'h1357, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        idle(1);
        do_reset();

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: rp = m_pin;
                1: rp = DEF;
                2: rp = 16'($urandom);
                default: rp = {4'($urandom_range(0, 9)),
                               4'($urandom_range(0, 9)),
                               4'($urandom_range(0, 9)),
                               4'($urandom_range(0, 9))};
            endcase
            step($urandom_range(0, 3) == 0, rp, $urandom_range(0, 4) == 0);
        end
        idle(2);
        @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
